// File: rtl/butterfly_xbar_out.sv
// -----------------------------------------------------------------------------
// butterfly_xbar_out
//
// Purpose:
//   Output stage of the butterfly datapath. On each accepted transfer it
//   applies the inverse crossbar permutation for the current stride. It packs
//   the eight butterfly words into two memory lines. The line pair goes into a
//   2-entry FIFO, and the memory write side drains that FIFO.
//
// Ports:
//   i_CLK                  clock, rising edge
//   i_RESETN               asynchronous active-low reset
//   i_STRIDE[9:0]          stride of the current stage, captured with the data
//   i_VALID / o_READY      input handshake (o_READY = occupancy < 2)
//   i_BUTTERFLY_n_TOP      butterfly top outputs, n = 1..4
//   i_BUTTERFLY_n_BOTTOM   butterfly bottom outputs, n = 1..4
//   o_WRITE_INPUT1/2       line 1 / line 2 write data (word k at [k*DATA_W +: DATA_W])
//   o_WRITE_VALID          head entry holds a line pair
//   i_WRITE_READY          memory accepts the head pair
//   o_STRIDE_ERR           sticky flag, set by an accepted transfer with stride 0
//   o_XFER_COUNT[15:0]     saturating pop counter (only with the macro below)
//
// Build options:
//   BUTTERFLY_XBAR_OUT_XFER_CNT_EN  adds o_XFER_COUNT and its counter
// -----------------------------------------------------------------------------
module butterfly_xbar_out #(
    parameter int DATA_W = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RESETN,
    input  logic [9:0]            i_STRIDE,
    input  logic                  i_VALID,
    output logic                  o_READY,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_1_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_2_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_3_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_4_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_1_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_2_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_3_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_4_BOTTOM,
    output logic [4*DATA_W-1:0]   o_WRITE_INPUT1,
    output logic [4*DATA_W-1:0]   o_WRITE_INPUT2,
    output logic                  o_WRITE_VALID,
    input  logic                  i_WRITE_READY,
`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
    output logic [15:0]           o_XFER_COUNT,
`endif
    output logic                  o_STRIDE_ERR
);

    typedef enum logic [1:0] {
        MODE_SW,
        MODE_S2,
        MODE_S1
    } xbar_mode_t;

    localparam int LINE_W = 4 * DATA_W;

    xbar_mode_t               mode;
    logic [LINE_W-1:0]        perm_line1;
    logic [LINE_W-1:0]        perm_line2;

    logic [1:0][LINE_W-1:0]   mem_line1;
    logic [1:0][LINE_W-1:0]   mem_line2;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic                     ready_en;
    logic [LINE_W-1:0]        head_line1;
    logic [LINE_W-1:0]        head_line2;
    logic                     stride_err;

    logic                     push;
    logic                     pop;

    // Stride 0 is not a legal stage. It falls back to the straight SW layout,
    // and the error flag records it.
    always_comb begin
        mode = MODE_SW;
        if (i_STRIDE == 10'd1) begin
            mode = MODE_S1;
        end else if (i_STRIDE == 10'd2) begin
            mode = MODE_S2;
        end
    end

    // Inverse crossbar. Concatenations list word 3 first, so word 0 lands
    // in the least significant DATA_W bits.
    always_comb begin
        perm_line1 = {i_BUTTERFLY_4_TOP, i_BUTTERFLY_3_TOP,
                      i_BUTTERFLY_2_TOP, i_BUTTERFLY_1_TOP};
        perm_line2 = {i_BUTTERFLY_4_BOTTOM, i_BUTTERFLY_3_BOTTOM,
                      i_BUTTERFLY_2_BOTTOM, i_BUTTERFLY_1_BOTTOM};
        case (mode)
            MODE_S2: begin
                perm_line1 = {i_BUTTERFLY_2_BOTTOM, i_BUTTERFLY_1_BOTTOM,
                              i_BUTTERFLY_2_TOP,    i_BUTTERFLY_1_TOP};
                perm_line2 = {i_BUTTERFLY_4_BOTTOM, i_BUTTERFLY_3_BOTTOM,
                              i_BUTTERFLY_4_TOP,    i_BUTTERFLY_3_TOP};
            end
            MODE_S1: begin
                perm_line1 = {i_BUTTERFLY_2_BOTTOM, i_BUTTERFLY_2_TOP,
                              i_BUTTERFLY_1_BOTTOM, i_BUTTERFLY_1_TOP};
                perm_line2 = {i_BUTTERFLY_4_BOTTOM, i_BUTTERFLY_4_TOP,
                              i_BUTTERFLY_3_BOTTOM, i_BUTTERFLY_3_TOP};
            end
            default: begin
            end
        endcase
    end

    // ready_en holds o_READY low through reset. It lets o_READY rise on the
    // first clock edge after reset is released.
    assign o_READY       = ready_en && (count != 2'd2);
    assign o_WRITE_VALID = (count != 2'd0);
    assign push          = i_VALID && o_READY;
    assign pop           = o_WRITE_VALID && i_WRITE_READY;

    assign o_WRITE_INPUT1 = head_line1;
    assign o_WRITE_INPUT2 = head_line2;
    assign o_STRIDE_ERR   = stride_err;

    // FIFO storage and pointers. The head registers are loaded separately from
    // the storage, so the outputs keep the last popped pair while the FIFO is
    // empty instead of showing whichever stale slot rd_ptr happens to point at.
    always_ff @(posedge i_CLK or negedge i_RESETN) begin
        if (!i_RESETN) begin
            mem_line1  <= '0;
            mem_line2  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            ready_en   <= 1'b0;
            head_line1 <= '0;
            head_line2 <= '0;
            stride_err <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                mem_line1[wr_ptr] <= perm_line1;
                mem_line2[wr_ptr] <= perm_line2;
                wr_ptr            <= ~wr_ptr;
                if (i_STRIDE == 10'd0) begin
                    stride_err <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // The new pair becomes the head if nothing will be left in front
            // of it. Otherwise a pop from a full FIFO promotes the second entry.
            if (push && ((count == 2'd0) || (pop && (count == 2'd1)))) begin
                head_line1 <= perm_line1;
                head_line2 <= perm_line2;
            end else if (pop && (count == 2'd2)) begin
                head_line1 <= mem_line1[~rd_ptr];
                head_line2 <= mem_line2[~rd_ptr];
            end
        end
    end

`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
    logic [15:0] xfer_count;

    // Counts pairs taken by memory. It saturates rather than wrapping.
    always_ff @(posedge i_CLK or negedge i_RESETN) begin
        if (!i_RESETN) begin
            xfer_count <= 16'd0;
        end else if (pop && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end

    assign o_XFER_COUNT = xfer_count;
`endif

endmodule

// File: tb/tb_butterfly_xbar_out.sv
// -----------------------------------------------------------------------------
// tb_butterfly_xbar_out
//
// Directed testbench for butterfly_xbar_out using the default DATA_W = 32.
// All expected line values are written out by hand from the permutation
// tables.
// -----------------------------------------------------------------------------
module tb_butterfly_xbar_out;

    localparam int DATA_W = 32;

    localparam logic [127:0] SW_L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] SW_L2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] S2_L1 = 128'hBBBBBBBB_AAAAAAAA_22222222_11111111;
    localparam logic [127:0] S2_L2 = 128'hDDDDDDDD_CCCCCCCC_44444444_33333333;
    localparam logic [127:0] S1_L1 = 128'hBBBBBBBB_22222222_AAAAAAAA_11111111;
    localparam logic [127:0] S1_L2 = 128'hDDDDDDDD_44444444_CCCCCCCC_33333333;

    logic                clk;
    logic                rst_n;
    logic [9:0]          stride;
    logic                valid;
    logic                ready;
    logic [DATA_W-1:0]   top1, top2, top3, top4;
    logic [DATA_W-1:0]   bot1, bot2, bot3, bot4;
    logic [4*DATA_W-1:0] line1;
    logic [4*DATA_W-1:0] line2;
    logic                write_valid;
    logic                write_ready;
    logic                stride_err;
`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
    logic [15:0]         xfer_count;
`endif

    int total_count;
    int bad_count;

    butterfly_xbar_out #(
        .DATA_W(DATA_W)
    ) dut (
        .i_CLK                (clk),
        .i_RESETN             (rst_n),
        .i_STRIDE             (stride),
        .i_VALID              (valid),
        .o_READY              (ready),
        .i_BUTTERFLY_1_TOP    (top1),
        .i_BUTTERFLY_2_TOP    (top2),
        .i_BUTTERFLY_3_TOP    (top3),
        .i_BUTTERFLY_4_TOP    (top4),
        .i_BUTTERFLY_1_BOTTOM (bot1),
        .i_BUTTERFLY_2_BOTTOM (bot2),
        .i_BUTTERFLY_3_BOTTOM (bot3),
        .i_BUTTERFLY_4_BOTTOM (bot4),
        .o_WRITE_INPUT1       (line1),
        .o_WRITE_INPUT2       (line2),
        .o_WRITE_VALID        (write_valid),
        .i_WRITE_READY        (write_ready),
`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
        .o_XFER_COUNT         (xfer_count),
`endif
        .o_STRIDE_ERR         (stride_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total_count++;
        if (observed !== expected) begin
            bad_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one result set. The mask is XORed into every word so that
    // back-to-back sets can be told apart.
    task automatic applyStimulus(input logic [9:0] s, input logic [31:0] mask);
        stride = s;
        top1 = 32'h11111111 ^ mask;
        top2 = 32'h22222222 ^ mask;
        top3 = 32'h33333333 ^ mask;
        top4 = 32'h44444444 ^ mask;
        bot1 = 32'hAAAAAAAA ^ mask;
        bot2 = 32'hBBBBBBBB ^ mask;
        bot3 = 32'hCCCCCCCC ^ mask;
        bot4 = 32'hDDDDDDDD ^ mask;
        valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A single transfer with memory ready: visible one cycle after accept,
    // popped on the next edge, and the data is held once the FIFO is empty.
    task automatic runSingle(input string tag, input logic [9:0] s,
                             input logic [127:0] exp1, input logic [127:0] exp2);
        applyStimulus(s, 32'h0);
        step();
        valid = 1'b0;
        checkOutput({tag, "_valid"}, 128'(write_valid), 128'd1);
        checkOutput({tag, "_line1"}, line1, exp1);
        checkOutput({tag, "_line2"}, line2, exp2);
        step();
        checkOutput({tag, "_empty"}, 128'(write_valid), 128'd0);
        checkOutput({tag, "_hold"}, line1, exp1);
    endtask

    initial begin
        total_count = 0;
        bad_count   = 0;
        rst_n       = 1'b0;
        valid       = 1'b0;
        write_ready = 1'b0;
        stride      = 10'd0;
        {top1, top2, top3, top4, bot1, bot2, bot3, bot4} = '0;

        #12;
        checkOutput("rst_ready", 128'(ready), 128'd0);
        checkOutput("rst_wvalid", 128'(write_valid), 128'd0);
        checkOutput("rst_line1", line1, 128'd0);
        checkOutput("rst_line2", line2, 128'd0);
        checkOutput("rst_err", 128'(stride_err), 128'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 128'(ready), 128'd0);
        step();
        checkOutput("ready_after_edge", 128'(ready), 128'd1);

        write_ready = 1'b1;
        runSingle("sw8", 10'd8, SW_L1, SW_L2);
        runSingle("s2", 10'd2, S2_L1, S2_L2);
        runSingle("s1", 10'd1, S1_L1, S1_L2);
        runSingle("sw3", 10'd3, SW_L1, SW_L2);
        runSingle("sw1023", 10'd1023, SW_L1, SW_L2);
        checkOutput("err_still_low", 128'(stride_err), 128'd0);

        // Push X, then push Y while X pops: Y must become the head.
        applyStimulus(10'd8, 32'h0);
        step();
        applyStimulus(10'd1, 32'h0);
        step();
        valid = 1'b0;
        checkOutput("pp_valid", 128'(write_valid), 128'd1);
        checkOutput("pp_line1", line1, S1_L1);
        checkOutput("pp_line2", line2, S1_L2);
        step();
        checkOutput("pp_empty", 128'(write_valid), 128'd0);

        // Backpressure: A (SW) and B (S1) are accepted, and C (S2) is refused.
        write_ready = 1'b0;
        applyStimulus(10'd8, 32'h0);
        step();
        checkOutput("bp_ready1", 128'(ready), 128'd1);
        applyStimulus(10'd1, 32'h0);
        step();
        checkOutput("bp_ready_full", 128'(ready), 128'd0);
        checkOutput("bp_head_a", line1, SW_L1);
        applyStimulus(10'd2, 32'h0);
        step();
        valid = 1'b0;
        checkOutput("bp_still_full", 128'(ready), 128'd0);
        checkOutput("bp_stable_l1", line1, SW_L1);
        checkOutput("bp_stable_l2", line2, SW_L2);
        write_ready = 1'b1;
        step();
        checkOutput("bp_pop_ready", 128'(ready), 128'd1);
        checkOutput("bp_head_b_l1", line1, S1_L1);
        checkOutput("bp_head_b_l2", line2, S1_L2);
        checkOutput("bp_head_b_valid", 128'(write_valid), 128'd1);
        step();
        checkOutput("bp_drained", 128'(write_valid), 128'd0);
        checkOutput("bp_no_c", line1, S1_L1);

        // A stride 0 transfer uses the SW layout and sets the sticky error flag.
        runSingle("stride0", 10'd0, SW_L1, SW_L2);
        checkOutput("err_set", 128'(stride_err), 128'd1);
        runSingle("after_err", 10'd1, S1_L1, S1_L2);
        checkOutput("err_sticky", 128'(stride_err), 128'd1);
`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
        checkOutput("xfer_count", 128'(xfer_count), 128'd11);
`endif

        // Fill the FIFO with a masked set, then reset in mid-cycle.
        write_ready = 1'b0;
        applyStimulus(10'd8, 32'h0F0F0F0F);
        step();
        step();
        valid = 1'b0;
        checkOutput("pre_rst_full", 128'(ready), 128'd0);
        checkOutput("pre_rst_mask", line1, SW_L1 ^ {4{32'h0F0F0F0F}});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_wvalid", 128'(write_valid), 128'd0);
        checkOutput("async_ready", 128'(ready), 128'd0);
        checkOutput("async_line1", line1, 128'd0);
        checkOutput("async_line2", line2, 128'd0);
        checkOutput("async_err", 128'(stride_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_ready", 128'(ready), 128'd1);
        checkOutput("post_rst_empty", 128'(write_valid), 128'd0);
`ifdef BUTTERFLY_XBAR_OUT_XFER_CNT_EN
        checkOutput("post_rst_count", 128'(xfer_count), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/butterfly_xbar_out.md
BUTTERFLY_XBAR_OUT -- requirements
Module: butterfly_xbar_out

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the width of one butterfly word; write ports are 4*DATA_W wide.
REQ-002 SHALL have port i_CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_RESETN, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port i_STRIDE, input, 10, the stride of the current butterfly stage, sampled with the data.
REQ-005 SHALL have port i_VALID, input, 1, which qualifies the butterfly results presented this cycle.
REQ-006 SHALL have port o_READY, output, 1, which is high when the block can accept a result set.
REQ-007 SHALL have ports i_BUTTERFLY_n_TOP (n=1..4), input, DATA_W each, the butterfly top outputs.
REQ-008 SHALL have ports i_BUTTERFLY_n_BOTTOM (n=1..4), input, DATA_W each, the butterfly bottom outputs.
REQ-009 SHALL have port o_WRITE_INPUT1, output, 4*DATA_W, the write data for memory line 1 (word k at bits [k*DATA_W +: DATA_W]).
REQ-010 SHALL have port o_WRITE_INPUT2, output, 4*DATA_W, the write data for memory line 2.
REQ-011 SHALL have port o_WRITE_VALID, output, 1, which is high while the buffer head holds a line pair.
REQ-012 SHALL have port i_WRITE_READY, input, 1, through which memory accepts the head pair.
REQ-013 SHALL have port o_STRIDE_ERR, output, 1, a sticky flag set by any accepted transfer with stride 0.

Function
REQ-014 SHALL accept a transfer on a rising edge where i_VALID and o_READY are both high; i_STRIDE and all 8 words are captured on that edge.
REQ-015 SHALL permute the data at accept time using inverse-xbar modes: stride==1 gives mode S1, stride==2 gives mode S2, every other nonzero stride gives mode SW, and stride==0 gives mode SW with the error flag.
REQ-016 In mode SW, line1 words 3..0 SHALL be {top4,top3,top2,top1} and line2 words 3..0 SHALL be {bot4,bot3,bot2,bot1}.
REQ-017 In mode S2, line1 SHALL be {bot2,bot1,top2,top1} and line2 SHALL be {bot4,bot3,top4,top3}.
REQ-018 In mode S1, line1 SHALL be {bot2,top2,bot1,top1} and line2 SHALL be {bot4,top4,bot3,top3}.
REQ-019 SHALL store accepted pairs in a 2-entry FIFO (occupancy 0..2, read and write pointers wrap); outputs are driven from the head entry register, with no combinational path from inputs to outputs.
REQ-020 Latency SHALL be exactly 1 cycle: when empty, data accepted at edge N drives o_WRITE_VALID high after edge N.
REQ-021 o_READY SHALL equal (occupancy < 2) and SHALL NOT depend on i_WRITE_READY.
REQ-022 SHALL pop the head on an edge where o_WRITE_VALID and i_WRITE_READY are both high.
REQ-023 On a simultaneous push and pop at occupancy 1, occupancy SHALL stay 1 and the new pair becomes the head next cycle.
REQ-024 When full, i_VALID SHALL be ignored, with no overwrite and no accept.
REQ-025 When empty, o_WRITE_VALID SHALL be 0 and o_WRITE_INPUT1/2 SHALL hold their last values, or 0 after reset.
REQ-026 Output data SHALL remain stable while o_WRITE_VALID is high and i_WRITE_READY is low.

Reset
REQ-027 Asserting i_RESETN low at any time, including mid-transfer, SHALL immediately clear the FIFO and pointers and drive o_READY=0, o_WRITE_VALID=0, o_WRITE_INPUT1/2=0 and o_STRIDE_ERR=0; buffered data is discarded.
REQ-028 o_READY SHALL rise on the first rising edge after i_RESETN deasserts.

Configuration
REQ-029 With macro BUTTERFLY_XBAR_OUT_XFER_CNT_EN defined, the block SHALL add output o_XFER_COUNT (16 bits, reset to 0) that increments on each pop and saturates at 16'hFFFF; without the macro, the port and counter SHALL be absent.

Verification
Common stimulus: top1..4 = 11111111, 22222222, 33333333, 44444444; bot1..4 = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; memory always ready.
REQ-030 Stride 8, common stimulus -> next cycle o_WRITE_INPUT1=44444444_33333333_22222222_11111111 and o_WRITE_INPUT2=DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA.
REQ-031 Stride 2, common stimulus -> o_WRITE_INPUT1=BBBBBBBB_AAAAAAAA_22222222_11111111 and o_WRITE_INPUT2=DDDDDDDD_CCCCCCCC_44444444_33333333.
REQ-032 Stride 1, common stimulus -> o_WRITE_INPUT1=BBBBBBBB_22222222_AAAAAAAA_11111111 and o_WRITE_INPUT2=DDDDDDDD_44444444_CCCCCCCC_33333333.
REQ-033 i_WRITE_READY=0 while 3 sets are offered back-to-back -> first 2 accepted, o_READY=0 on the third, outputs stable; then i_WRITE_READY=1 -> 2 pops in order, o_READY returns.
REQ-034 Stride 0 transfer -> data uses mode SW and o_STRIDE_ERR=1 stays high through later transfers until reset.
REQ-035 Reset asserted with occupancy 2 -> o_WRITE_VALID=0 immediately, and after deassertion the FIFO is empty; with BUTTERFLY_XBAR_OUT_XFER_CNT_EN, o_XFER_COUNT also reads 0.
